// File: rtl/switch_debounce_fsm.sv
// Debounces a raw switch level into a registered level plus a one-cycle rising tick; latency STABLE_CYCLES+1 edges
// (+2 with SWITCH_DEBOUNCE_SYNC_EN, which adds a two-flop input synchronizer); no backpressure, one sample per clock.
module switch_debounce_fsm #(
  parameter int unsigned STABLE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d;
  logic          tick_d;
  logic          sw_s;

`ifdef SWITCH_DEBOUNCE_SYNC_EN
  logic sync_q1, sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sw;
      sync_q2 <= sync_q1;
    end
  end

  assign sw_s = sync_q2;
`else
  assign sw_s = sw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ZERO;
      cnt_q    <= '0;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      db_level <= level_d;
      db_tick  <= tick_d;
    end
  end

  // An opposite sample is tested before the terminal count, so it wins on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (sw_s) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_d = ZERO;
        end else if (cnt_q == TERM) begin
          state_d = ONE;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_d = ONE;
        end else if (cnt_q == TERM) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ONE) || (state_d == WAIT0);
  end

endmodule
